// File: rtl/stream_mux_rr.sv
// NUM_CH-to-1 valid/ready stream multiplexer with a registered output stage.
// The channel is chosen either by a fixed select or by round-robin arbitration.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CH*WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]       in_valid_i,
  output logic [NUM_CH-1:0]       in_ready_o,
  input  logic                    mode_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_ch_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;
  logic             fix_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_valid;
  logic             load;
  logic             xfer;

  assign load = !out_valid_o || out_ready_i;

  // Walk offsets from the highest down so the channel closest to ptr wins.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_w;
    rr_valid = 1'b0;
    rr_idx   = '0;
    idx      = 0;
    idx_w    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = SEL_W'(idx);
      if (in_valid_i[idx_w]) begin
        rr_valid = 1'b1;
        rr_idx   = idx_w;
      end
    end
  end

  always_comb begin
    fix_valid = 1'b0;
    if (int'(sel_i) < NUM_CH) fix_valid = in_valid_i[sel_i];
  end

  assign grant_idx   = mode_i ? rr_idx : sel_i;
  assign grant_valid = mode_i ? rr_valid : fix_valid;

  always_comb begin
    in_ready_o = '0;
    if (!reset_i && load && grant_valid) in_ready_o[grant_idx] = 1'b1;
  end

  assign xfer = |in_ready_o;

  // A transfer refills the output register; otherwise a consumed beat drains it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      ptr         <= '0;
    end else begin
      if (xfer) begin
        out_valid_o <= 1'b1;
        out_data_o  <= in_data_i[int'(grant_idx)*WIDTH +: WIDTH];
        out_ch_o    <= grant_idx;
        if (mode_i)
          ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: accepted beats are queued at issue time
// and a separate monitor pops them as the output handshake completes.
module tb_stream_mux_rr;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_valid_i;
  logic [3:0]  in_ready_o;
  logic        mode_i;
  logic [1:0]  sel_i;
  logic [7:0]  out_data_o;
  logic [1:0]  out_ch_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .mode_i(mode_i), .sel_i(sel_i), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  // Monitor: each completed output handshake must match the oldest queued beat.
  always @(negedge clk) begin
    if (!reset_i && out_valid_o && out_ready_i) begin
      beat_t exp_b;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL beat_unexpected got ch=%0d data=%h, none expected", out_ch_o, out_data_o);
      end else begin
        exp_b = sb.pop_front();
        if (out_data_o !== exp_b.data || out_ch_o !== exp_b.ch) begin
          errors++;
          $display("[TB] FAIL beat got ch=%0d data=%h expected ch=%0d data=%h",
                   out_ch_o, out_data_o, exp_b.ch, exp_b.data);
        end
      end
    end
  end

  // Drive one cycle of inputs, check the grant, and queue the accepted beat.
  task automatic applyStimulus(input logic [3:0] valid, input logic mode, input logic [1:0] sel,
                               input logic ordy, input logic [3:0] exp_ready,
                               input logic [7:0] exp_data, input logic [1:0] exp_ch);
    in_valid_i  = valid;
    mode_i      = mode;
    sel_i       = sel;
    out_ready_i = ordy;
    #2;
    checks++;
    if (in_ready_o !== exp_ready) begin
      errors++;
      $display("[TB] FAIL in_ready got %b expected %b", in_ready_o, exp_ready);
    end
    if (exp_ready != 4'b0000) sb.push_back('{data: exp_data, ch: exp_ch});
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic valid, input logic [7:0] data,
                             input logic [1:0] ch);
    checks++;
    if (out_valid_o !== valid || out_data_o !== data || out_ch_o !== ch) begin
      errors++;
      $display("[TB] FAIL %s got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
               name, out_valid_o, out_data_o, out_ch_o, valid, data, ch);
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    in_data_i   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    in_valid_i  = 4'b1111;
    mode_i      = 1'b0;
    sel_i       = 2'd0;
    out_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b expected 0000", in_ready_o);
    end
    checkOutput("reset", 1'b0, 8'h00, 2'd0);
    reset_i = 1'b0;

    // Fixed select on channel 2.
    repeat (3) applyStimulus(4'b1111, 1'b0, 2'd2, 1'b1, 4'b0100, 8'hC2, 2'd2);
    checkOutput("fixed_out", 1'b1, 8'hC2, 2'd2);

    // Round-robin fairness from pointer 0.
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0, 2'd0);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010, 8'hB1, 2'd1);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 8'hC2, 2'd2);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000, 8'hD3, 2'd3);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0, 2'd0);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010, 8'hB1, 2'd1);

    // Skip and wrap: ptr=3 after ch2, only ch1 valid, then ptr=2 proven.
    applyStimulus(4'b0100, 1'b1, 2'd0, 1'b1, 4'b0100, 8'hC2, 2'd2);
    applyStimulus(4'b0010, 1'b1, 2'd0, 1'b1, 4'b0010, 8'hB1, 2'd1);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 8'hC2, 2'd2);

    // Backpressure with B1 held, then release with no bubble.
    applyStimulus(4'b0010, 1'b1, 2'd0, 1'b1, 4'b0010, 8'hB1, 2'd1);
    repeat (3) begin
      applyStimulus(4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 8'h00, 2'd0);
      checkOutput("stall", 1'b1, 8'hB1, 2'd1);
    end
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 8'hC2, 2'd2);
    checkOutput("no_bubble", 1'b1, 8'hC2, 2'd2);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 8'h00, 2'd0);
    checkOutput("drain", 1'b0, 8'hC2, 2'd2);

    // Mode switch keeps ptr=3; fixed select on an idle channel grants nothing.
    applyStimulus(4'b1111, 1'b0, 2'd1, 1'b1, 4'b0010, 8'hB1, 2'd1);
    applyStimulus(4'b1111, 1'b1, 2'd1, 1'b1, 4'b1000, 8'hD3, 2'd3);
    applyStimulus(4'b1110, 1'b0, 2'd0, 1'b1, 4'b0000, 8'h00, 2'd0);

    // Reset mid-operation: hold A0, then reset with the consumer ready.
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0, 2'd0);
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 8'h00, 2'd0);
    reset_i = 1'b1;
    sb.delete();
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0000, 8'h00, 2'd0);
    checkOutput("reset_mid", 1'b0, 8'h00, 2'd0);
    reset_i = 1'b0;
    applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0, 2'd0);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 8'h00, 2'd0);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 8'h00, 2'd0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain got %0d beats left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's fixed 4:1 bit multiplexer. Selects one of NUM_CH streams, each WIDTH bits wide, into a single registered output stream.
- Every input and the output use valid/ready handshakes.
- Two selection modes: fixed select (software-driven, like the original mux) and round-robin arbitration.
- Sits between multiple producers and one shared consumer, e.g. the datapath feeding a single shared bus.

Parameters:
NUM_CH, 4, number of input channels (>=2)
WIDTH, 8, data width per channel in bits
SEL_W, $clog2(NUM_CH), width of select and channel-index fields (derived, not overridden)

Ports:
clk_i  input  1  clock, all state updates on rising edge
reset_i  input  1  synchronous active-high reset
in_data_i  input  NUM_CH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
in_valid_i  input  NUM_CH  channel k has a beat
in_ready_o  output  NUM_CH  channel k beat accepted this cycle
mode_i  input  1  0 = fixed select, 1 = round-robin
sel_i  input  SEL_W  channel used when mode_i=0
out_data_o  output  WIDTH  registered selected data
out_ch_o  output  SEL_W  index of channel that supplied out_data_o
out_valid_o  output  1  output register holds a beat
out_ready_i  input  1  consumer accepts the beat

Behaviour:
- Reset (reset_i=1 at a clock edge): out_valid_o=0, out_data_o=0, out_ch_o=0, rr pointer=0.
  - in_ready_o is all-zero during any cycle where reset_i=1.
  - Reset mid-transfer drops the held beat; no input beat is accepted in that cycle.
- Load enable: load = !out_valid_o || out_ready_i. This gives full throughput of one beat per cycle with no bubble when the consumer is always ready.
- Grant, combinational from current inputs:
  - mode_i=0: grant valid iff sel_i<NUM_CH and in_valid_i[sel_i]; grant index = sel_i. sel_i>=NUM_CH (non-power-of-2 NUM_CH) gives no grant.
  - mode_i=1: grant index = first k with in_valid_i[k], searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 (wrap-around). Grant valid iff any in_valid_i is set.
- in_ready_o[k] = load && grant valid && grant index==k. At most one bit is set per cycle.
- Transfer on channel k when in_valid_i[k] && in_ready_o[k]. On the next edge: out_data_o = channel k data, out_ch_o = k, out_valid_o = 1.
  - Latency: input acceptance to output visible is exactly 1 cycle.
- Output drain: if out_ready_i && out_valid_o and no input transfer occurs, out_valid_o -> 0 next edge. out_data_o and out_ch_o hold their last values.
- Output stall: while out_valid_o && !out_ready_i, out_data_o and out_ch_o remain stable and in_ready_o is all-zero.
- rr pointer:
  - Updates only on an input transfer while mode_i=1: ptr <= (k==NUM_CH-1) ? 0 : k+1.
  - Unchanged in mode 0 and on cycles with no transfer.
- Mode switch: takes effect the same cycle for grant computation; the pointer is preserved across switches.
- Fairness: in mode 1, with all channels continuously valid and out_ready_i=1, grants cycle 0,1,...,NUM_CH-1,0,... with no channel granted twice within any NUM_CH consecutive transfers.
- Protocol rules:
  - Producers must hold data stable while valid and not ready; the block does not check this.
  - The block never depends on in_valid_i being stable once ready is low.

Test Plan:
- Reset then idle (NUM_CH=4, WIDTH=8): assert reset_i 2 cycles -> out_valid_o=0, out_data_o=8'h00, out_ch_o=0, in_ready_o=4'b0000.
- Fixed select: mode_i=0, sel_i=2, in_valid_i=4'b1111, data ch0..3 = 8'hA0, 8'hB1, 8'hC2, 8'hD3, out_ready_i=1 -> in_ready_o=4'b0100 each cycle; one cycle later out_data_o=8'hC2, out_ch_o=2, out_valid_o=1 continuously.
- Round-robin fairness: mode_i=1, in_valid_i=4'b1111, out_ready_i=1 from reset -> out_ch_o sequence 0,1,2,3,0,1 on consecutive cycles.
- Round-robin skip and wrap: mode_i=1, ptr=3 after granting ch2, in_valid_i=4'b0010 -> ch1 granted (wraps past 3, 0); next ptr=2.
- Backpressure: out_valid_o=1 with out_data_o=8'hB1, out_ready_i=0 for 3 cycles with all inputs valid -> in_ready_o=4'b0000, outputs unchanged. Then out_ready_i=1 -> a new beat is accepted the same cycle and out_data_o updates on the next edge (no bubble).
- Reset mid-operation: held beat with out_ready_i=0, pulse reset_i one cycle -> next cycle out_valid_o=0 and ptr=0. The beat is lost and no input is accepted during the reset cycle.
